// File: rtl/kb_pkg.sv
// Shared constants for the HID-to-Apple IIe keyboard path: HID usages,
// modifier bit positions, latch FSM states and soft-switch addresses.
package kb_pkg;

    localparam logic [7:0] HID_NONE  = 8'h00;
    localparam logic [7:0] HID_A     = 8'h04;
    localparam logic [7:0] HID_Z     = 8'h1D;
    localparam logic [7:0] HID_1     = 8'h1E;
    localparam logic [7:0] HID_0     = 8'h27;
    localparam logic [7:0] HID_ENTER = 8'h28;
    localparam logic [7:0] HID_ESC   = 8'h29;
    localparam logic [7:0] HID_BKSP  = 8'h2A;
    localparam logic [7:0] HID_TAB   = 8'h2B;
    localparam logic [7:0] HID_SPACE = 8'h2C;
    localparam logic [7:0] HID_MINUS = 8'h2D;
    localparam logic [7:0] HID_SLASH = 8'h38;
    localparam logic [7:0] HID_CAPS  = 8'h39;
    localparam logic [7:0] HID_RIGHT = 8'h4F;
    localparam logic [7:0] HID_LEFT  = 8'h50;
    localparam logic [7:0] HID_DOWN  = 8'h51;
    localparam logic [7:0] HID_UP    = 8'h52;

    localparam int unsigned MOD_LCTRL  = 0;
    localparam int unsigned MOD_LSHIFT = 1;
    localparam int unsigned MOD_RCTRL  = 4;
    localparam int unsigned MOD_RSHIFT = 5;

    localparam logic [15:0] KBD     = 16'hC000;
    localparam logic [15:0] KBDSTRB = 16'hC010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } kb_state_e;

endpackage

// File: rtl/hid_to_ascii.sv
// Combinational translation of one HID usage plus shift/ctrl/caps into
// 7-bit Apple ASCII; valid is low for keys with no Apple equivalent.
module hid_to_ascii
    import kb_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       ctrl,
    input  logic       caps,
    output logic [6:0] ascii,
    output logic       valid
);

    logic [6:0] w_off;

    always_comb begin
        ascii = 7'h00;
        valid = 1'b1;
        w_off = 7'(code - HID_A);
        if (code inside {[HID_A:HID_Z]}) begin
            // Ctrl outranks shift; caps only ever raises letters
            if (ctrl)                ascii = 7'h01 + w_off;
            else if (shift || caps)  ascii = 7'h41 + w_off;
            else                     ascii = 7'h61 + w_off;
        end else begin
            unique case (code)
                HID_1:     ascii = shift ? 7'h21 : 7'h31;
                8'h1F:     ascii = shift ? 7'h40 : 7'h32;
                8'h20:     ascii = shift ? 7'h23 : 7'h33;
                8'h21:     ascii = shift ? 7'h24 : 7'h34;
                8'h22:     ascii = shift ? 7'h25 : 7'h35;
                8'h23:     ascii = shift ? 7'h5E : 7'h36;
                8'h24:     ascii = shift ? 7'h26 : 7'h37;
                8'h25:     ascii = shift ? 7'h2A : 7'h38;
                8'h26:     ascii = shift ? 7'h28 : 7'h39;
                HID_0:     ascii = shift ? 7'h29 : 7'h30;
                HID_ENTER: ascii = 7'h0D;
                HID_ESC:   ascii = 7'h1B;
                HID_BKSP:  ascii = 7'h08;
                HID_TAB:   ascii = 7'h09;
                HID_SPACE: ascii = 7'h20;
                HID_MINUS: ascii = shift ? 7'h5F : 7'h2D;
                8'h2E:     ascii = shift ? 7'h2B : 7'h3D;
                8'h2F:     ascii = shift ? 7'h7B : 7'h5B;
                8'h30:     ascii = shift ? 7'h7D : 7'h5D;
                8'h31:     ascii = shift ? 7'h7C : 7'h5C;
                8'h32:     ascii = shift ? 7'h7E : 7'h23;
                8'h33:     ascii = shift ? 7'h3A : 7'h3B;
                8'h34:     ascii = shift ? 7'h22 : 7'h27;
                8'h35:     ascii = shift ? 7'h7E : 7'h60;
                8'h36:     ascii = shift ? 7'h3C : 7'h2C;
                8'h37:     ascii = shift ? 7'h3E : 7'h2E;
                HID_SLASH: ascii = shift ? 7'h3F : 7'h2F;
                HID_RIGHT: ascii = 7'h15;
                HID_LEFT:  ascii = 7'h08;
                HID_DOWN:  ascii = 7'h0A;
                HID_UP:    ascii = 7'h0B;
                default:   valid = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/hid_key_latch.sv
// Apple IIe keyboard latch: registers the HID key, runs press/auto-repeat
// FSM and caps lock, and serves CPU reads of $C000-$C01F.
module hid_key_latch
    import kb_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 3_333_333
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  keycode,
    input  logic [7:0]  modifiers,
    input  logic [15:0] addr,
    input  logic        rw,
    input  logic        bus_en,
    output logic [7:0]  dout,
    output logic        dsel,
    output logic        strobe,
    output logic        key_down,
    output logic        caps_lock
);

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    kb_state_e        r_state, w_state_nxt;
    logic [7:0]       r_kc_q, r_kc_prev, r_mod_q;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [6:0]       r_ascii, w_ascii_nxt;
    logic             r_strobe, w_strobe_nxt;
    logic             r_caps, w_caps_nxt;

    logic [6:0] w_xlat;
    logic       w_valid, w_new_code, w_set, w_strb_acc, w_sel_kbd, w_sel_strb;
    logic       w_unused;

    hid_to_ascii u_xlat (
        .code  (r_kc_q),
        .shift (r_mod_q[MOD_LSHIFT] | r_mod_q[MOD_RSHIFT]),
        .ctrl  (r_mod_q[MOD_LCTRL]  | r_mod_q[MOD_RCTRL]),
        .caps  (r_caps),
        .ascii (w_xlat),
        .valid (w_valid)
    );

    assign w_sel_kbd  = (addr[15:4] == KBD[15:4]);
    assign w_sel_strb = (addr[15:4] == KBDSTRB[15:4]);
    assign w_strb_acc = bus_en && w_sel_strb;
    assign w_new_code = (r_kc_q != r_kc_prev) && (r_kc_q != HID_NONE);
    assign w_unused   = ^{addr[3:0], r_mod_q[7:6], r_mod_q[3:2]};

    // Next-state, counter and latch update
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ascii_nxt = r_ascii;
        w_set       = 1'b0;
        w_caps_nxt  = r_caps ^ (w_new_code && (r_kc_q == HID_CAPS));
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_new_code && w_valid) begin
                    w_set       = 1'b1;
                    w_ascii_nxt = w_xlat;
                    w_state_nxt = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (w_new_code) begin
                    w_cnt_nxt = '0;
                    if (w_valid) begin
                        w_set       = 1'b1;
                        w_ascii_nxt = w_xlat;
                        w_state_nxt = DELAY;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (r_kc_q == HID_NONE) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (r_cnt == ((r_state == DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                    w_set       = 1'b1;
                    w_ascii_nxt = w_xlat;
                    w_cnt_nxt   = '0;
                    w_state_nxt = REPEAT;
                end else begin
                    w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // A strobe set on the same edge as a $C01x clear must survive
        w_strobe_nxt = w_set ? 1'b1 : (w_strb_acc ? 1'b0 : r_strobe);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_kc_q    <= '0;
            r_kc_prev <= '0;
            r_mod_q   <= '0;
            r_cnt     <= '0;
            r_ascii   <= '0;
            r_strobe  <= 1'b0;
            r_caps    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_kc_q    <= keycode;
            r_kc_prev <= r_kc_q;
            r_mod_q   <= modifiers;
            r_cnt     <= w_cnt_nxt;
            r_ascii   <= w_ascii_nxt;
            r_strobe  <= w_strobe_nxt;
            r_caps    <= w_caps_nxt;
        end
    end

    assign strobe    = r_strobe;
    assign caps_lock = r_caps;
    assign key_down  = (r_state != IDLE);
    assign dsel      = rw && (w_sel_kbd || w_sel_strb);

    // Read mux: bit 7 is strobe at $C00x, key_down at $C01x
    always_comb begin
        dout = 8'h00;
        if (dsel) dout = w_sel_kbd ? {r_strobe, r_ascii} : {key_down, r_ascii};
    end

endmodule

// File: doc/hid_key_latch.md
# hid_key_latch

Converts the 8-bit USB HID keycode and modifier byte exported by the Nios keyboard system into the Apple IIe keyboard soft-switch interface, where the 6502 reads it. Holds the Apple key latch (7-bit ASCII plus strobe), implements auto-repeat and caps lock, and answers CPU accesses to $C000–$C01F. Its data output is merged into the MMU read path alongside RAM and ROM.

## Interface
Parameters:
- REPEAT_DELAY, 25_000_000 — cycles a key must be held before the first repeat (0.5 s at 50 MHz).
- REPEAT_PERIOD, 3_333_333 — cycles between subsequent repeats (about 15 Hz).

Ports:
- clk  in  1  system clock; the same clock as the CPU.
- reset  in  1  synchronous, active-high reset.
- keycode  in  8  HID usage of the first pressed key; 0 means no key.
- modifiers  in  8  HID modifier byte. Bit 0 is LCtrl, bit 1 LShift, bit 4 RCtrl, bit 5 RShift.
- addr  in  16  CPU address bus.
- rw  in  1  1 = read, 0 = write.
- bus_en  in  1  qualifies a valid CPU cycle on this clock.
- dout  out  8  read data; combinational from addr and state.
- dsel  out  1  high when this block drives the read bus.
- strobe  out  1  key-available flag; bit 7 of $C000.
- key_down  out  1  high while a mapped key is held.
- caps_lock  out  1  current caps-lock state, suitable for an LED.

## Operation
- keycode and modifiers are registered once (kc_q, mod_q). The key code is translated from kc_q and mod_q.
- Translation rules:
  - Letters 0x04–0x1D produce 'a'–'z'. Shift or caps_lock gives uppercase.
  - Ctrl+letter gives 0x01–0x1A. Ctrl takes priority over shift.
  - Digit keys 0x1E–0x27 give '1'–'9','0'. With shift they give !@#$%^&*().
  - Punctuation 0x2D–0x38 follows the US layout, with shifted forms.
  - Fixed codes: Enter 0x28→0x0D, Esc 0x29→0x1B, Backspace 0x2A→0x08, Tab 0x2B→0x09, Space 0x2C→0x20, Right 0x4F→0x15, Left 0x50→0x08, Down 0x51→0x0A, Up 0x52→0x0B.
  - Anything else is unmapped.
- Caps lock (0x39): a press edge toggles caps_lock. It produces no strobe and does not enter HELD.
- States:
  - IDLE. A new mapped press (kc_q ≠ previous kc_q and kc_q ≠ 0) latches the ASCII value, sets strobe, clears the counter, and moves to DELAY.
  - DELAY. The counter increments each cycle.
    - A different nonzero mapped code latches the new key and restarts DELAY.
    - kc_q = 0 returns to IDLE.
    - Counter = REPEAT_DELAY−1 re-sets strobe, re-latches the current translation, clears the counter, and moves to REPEAT.
  - REPEAT. Same transitions as DELAY, but the threshold is REPEAT_PERIOD−1 and the state stays REPEAT.
- An unmapped new code while in DELAY or REPEAT returns to IDLE. The latch is retained.
- A change in modifiers alone produces no new strobe. A repeat does use the current modifiers.
- CPU interface:
  - A read of $C000–$C00F gives dout = {strobe, ascii}.
  - A read of $C010–$C01F gives dout = {key_down, ascii}.
  - dsel is high only for reads in $C000–$C01F.
  - Any bus_en cycle (read or write) at $C010–$C01F clears strobe at the next edge.
  - Writes never change ascii.
- key_down is high in DELAY and REPEAT.

## Timing
- Reset values:
  - ascii=0, strobe=0, caps_lock=1, state=IDLE.
  - kc_q=0, mod_q=0, counter=0.
  - key_down=0. dsel and dout follow addr/rw.
- Latency: strobe is high 2 clocks after keycode changes (one input register, then the latch).
- A clear and a strobe set in the same cycle: set wins, so strobe=1 with the new ASCII.
- A clear while strobe is already 0 has no effect.
- Counters saturate only through the state transitions. They are never compared beyond their thresholds. Width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
- Reset asserted mid-hold returns to IDLE. If the key is still held after reset, it is treated as a new press, because kc_q restarts at 0.

## Structure
- kb_pkg holds:
  - the HID usage constants and modifier bit indices;
  - the state enum (IDLE, DELAY, REPEAT);
  - the Apple soft-switch address constants KBD=$C000 and KBDSTRB=$C010.
- One combinational sub-module, hid_to_ascii. Inputs: code[7:0], shift, ctrl, caps. Outputs: ascii[6:0], valid.
- The top of the block holds the registers, the FSM, the repeat counter and the bus decode.

## Test plan
Simulation uses REPEAT_DELAY=20 and REPEAT_PERIOD=5.
- After reset, read $C000 → 0x00, dsel=1, caps_lock=1. Keycode 0x04 with no modifiers → after 2 clks, read $C000 → 0xC1 ('A' with strobe set).
- Read $C010 while 0x04 is held → 0xC1 (key_down=1). The next read of $C000 → 0x41.
- Hold 0x04 → strobe re-sets 20 clks after the first strobe, then every 5 clks. Each repeat is cleared by a $C010 write. Release → key_down=0, no further strobes.
- Caps lock press/release, then 0x04 → 0xE1 ('a'). LCtrl+0x06 → 0x83. Modifier 0x02 with 0x1F → 0xC0 ('@').
- Access $C010 on the same clk as a new key's strobe set → strobe=1 with the new ASCII. A write to $C000 changes nothing. A read of $C020 gives dsel=0.
- Unmapped code 0x3A → no strobe, latch unchanged. Reset asserted during REPEAT → IDLE, strobe=0, ascii=0.
